misaligned_access_unit: RTL

- Sequencing stage between the core's load/store path and the lane-level data memory port.
- Latches one load/store request and checks it for legality.
- Splits a word or halfword that crosses a 32-bit boundary into two aligned word accesses, then merges and sign/zero-extends read data.
- Returns a one-cycle `core_done` pulse with the result, or `core_fault` for an illegal request.

---
 rtl/misaligned_access_unit.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/misaligned_access_unit.sv
// ----------------------------------------------------------------------------
// misaligned_access_unit
//
// Sequencing stage between the core load/store path and a 32-bit, byte-lane
// data memory port. One request is latched and checked for legality. A
// halfword or word that crosses a 32-bit boundary is split into two aligned
// word accesses (LO at base, HI at base+4), and the read data is merged and
// sign/zero-extended before a one-cycle completion pulse.
//
// Build option:
//   MISALIGNED_SPLIT_EN  defined   -> boundary-crossing requests are split
//                        undefined -> boundary-crossing requests fault, and
//                                     the HI access path is not built
//
// Ports:
//   clock, reset             clock; asynchronous active-high reset
//   core_valid               request present, held until core_done
//   core_read_enable         load request
//   core_write_enable        store request
//   core_data_format[2:0]    [1:0] 00 byte / 01 half / 10 word, [2] unsigned
//   core_address[31:0]       byte address
//   core_write_data[31:0]    right-aligned store data
//   core_read_data[31:0]     extended load result, valid with core_done
//   core_done                one-cycle completion pulse
//   core_fault               pulses with core_done for a rejected request
//   mem_enable               memory access this cycle
//   mem_write                access is a write
//   mem_byte_enable[3:0]     byte lane enables
//   mem_address[31:0]        word-aligned address
//   mem_write_data[31:0]     lane-positioned store data
//   mem_read_data[31:0]      raw read word, valid the cycle after a read
// ----------------------------------------------------------------------------
module misaligned_access_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        core_valid,
    input  logic        core_read_enable,
    input  logic        core_write_enable,
    input  logic [2:0]  core_data_format,
    input  logic [31:0] core_address,
    input  logic [31:0] core_write_data,
    output logic [31:0] core_read_data,
    output logic        core_done,
    output logic        core_fault,
    output logic        mem_enable,
    output logic        mem_write,
    output logic [3:0]  mem_byte_enable,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [1:0] {ST_IDLE, ST_LO, ST_HI, ST_FIN} state_t;

    state_t      state_reg, state_next;
    logic        write_reg;
    logic [2:0]  fmt_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic        fault_reg;
`ifdef MISALIGNED_SPLIT_EN
    logic        split_reg;
    logic [31:0] lo_word_reg;
`endif

    // Request decode, only consulted while IDLE.
    logic req_illegal;
    logic req_split;
    logic req_fault;

    assign req_illegal = (core_data_format[1:0] == 2'b11) ||
                         (core_read_enable == core_write_enable);
    // off + size > 4: half at offset 3, or word at any non-zero offset.
    assign req_split   = ((core_data_format[1:0] == 2'b01) && (core_address[1:0] == 2'b11)) ||
                         ((core_data_format[1:0] == 2'b10) && (core_address[1:0] != 2'b00));
`ifdef MISALIGNED_SPLIT_EN
    assign req_fault   = req_illegal;
`else
    assign req_fault   = req_illegal || req_split;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            write_reg   <= 1'b0;
            fmt_reg     <= 3'b000;
            addr_reg    <= 32'h0;
            wdata_reg   <= 32'h0;
            fault_reg   <= 1'b0;
`ifdef MISALIGNED_SPLIT_EN
            split_reg   <= 1'b0;
            lo_word_reg <= 32'h0;
`endif
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_IDLE && core_valid) begin
                write_reg <= core_write_enable;
                fmt_reg   <= core_data_format;
                addr_reg  <= core_address;
                wdata_reg <= core_write_data;
                fault_reg <= req_fault;
`ifdef MISALIGNED_SPLIT_EN
                split_reg <= req_split;
`endif
            end
`ifdef MISALIGNED_SPLIT_EN
            // LO read data arrives while HI is on the bus.
            if (state_reg == ST_HI)
                lo_word_reg <= mem_read_data;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (core_valid) state_next = req_fault ? ST_FIN : ST_LO;
`ifdef MISALIGNED_SPLIT_EN
            ST_LO:   state_next = split_reg ? ST_HI : ST_FIN;
            ST_HI:   state_next = ST_FIN;
`else
            ST_LO:   state_next = ST_FIN;
            ST_HI:   state_next = ST_IDLE;
`endif
            ST_FIN:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Lane positioning from the latched request.
    logic [1:0]  off;
    logic [3:0]  mask4;
    logic [31:0] base_addr;
    logic [3:0]  be_lo;
    logic [31:0] wd_lo;

    assign off       = addr_reg[1:0];
    assign mask4     = (fmt_reg[1:0] == 2'b00) ? 4'h1 :
                       (fmt_reg[1:0] == 2'b01) ? 4'h3 : 4'hF;
    assign base_addr = {addr_reg[31:2], 2'b00};
    assign be_lo     = mask4 << off;
    assign wd_lo     = wdata_reg << {off, 3'b000};

`ifdef MISALIGNED_SPLIT_EN
    // Upper half of the 8-lane window: bytes pushed past lane 3 land in HI.
    logic [3:0]  be_hi;
    logic [31:0] wd_hi;
    assign be_hi = mask4 >> (3'd4 - {1'b0, off});
    assign wd_hi = wdata_reg >> (6'd32 - {1'b0, off, 3'b000});
`endif

    // Read merge: {hi,lo} >> 8*off, built from two 32-bit shifts.
    logic [31:0] lo_word;
    logic [31:0] hi_word;
    logic [31:0] merged;
    logic        sext;
    logic [31:0] load_result;

`ifdef MISALIGNED_SPLIT_EN
    assign lo_word = split_reg ? lo_word_reg : mem_read_data;
    assign hi_word = split_reg ? mem_read_data : 32'h0;
`else
    assign lo_word = mem_read_data;
    assign hi_word = 32'h0;
`endif
    assign merged = (lo_word >> {off, 3'b000}) |
                    (hi_word << (6'd32 - {1'b0, off, 3'b000}));
    assign sext   = ~fmt_reg[2];

    always_comb begin
        case (fmt_reg[1:0])
            2'b00:   load_result = {{24{sext & merged[7]}},  merged[7:0]};
            2'b01:   load_result = {{16{sext & merged[15]}}, merged[15:0]};
            default: load_result = merged;
        endcase
    end

    always_comb begin
        core_read_data  = 32'h0;
        core_done       = 1'b0;
        core_fault      = 1'b0;
        mem_enable      = 1'b0;
        mem_write       = 1'b0;
        mem_byte_enable = 4'h0;
        mem_address     = 32'h0;
        mem_write_data  = 32'h0;
        case (state_reg)
            ST_LO: begin
                mem_enable      = 1'b1;
                mem_write       = write_reg;
                mem_byte_enable = be_lo;
                mem_address     = base_addr;
                mem_write_data  = write_reg ? wd_lo : 32'h0;
            end
`ifdef MISALIGNED_SPLIT_EN
            ST_HI: begin
                mem_enable      = 1'b1;
                mem_write       = write_reg;
                mem_byte_enable = be_hi;
                mem_address     = base_addr + 32'd4;   // wraps modulo 2^32
                mem_write_data  = write_reg ? wd_hi : 32'h0;
            end
`endif
            ST_FIN: begin
                core_done      = 1'b1;
                core_fault     = fault_reg;
                core_read_data = (fault_reg || write_reg) ? 32'h0 : load_result;
            end
            default: ;
        endcase
    end

endmodule
